// File: rtl/hull_frame_sequencer_if.sv
// Bus bundle for hull_frame_sequencer: raster pixel stream, point-memory
// write port, hull-engine handshake and status outputs.
// Macro HULL_SEQ_TIMEOUT_EN adds the sticky timeout flag.
interface hull_frame_sequencer_if #(
  parameter int CNT_W   = 9,
  parameter int COORD_W = 11
);
  logic               pix_valid;
  logic               pix_fg;
  logic               pix_sof;
  logic               pix_eol;
  logic               pix_eof;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pt_we;
  logic [CNT_W-1:0]   pt_addr;
  logic [COORD_W-1:0] pt_x;
  logic [COORD_W-1:0] pt_y;
  logic               hull_start;
  logic [CNT_W-1:0]   hull_count;
  logic               hull_done;
  logic [CNT_W-1:0]   hull_top;
  logic               result_valid;
  logic [CNT_W-1:0]   hull_size;
  logic               degenerate;
  logic               overflow;
  logic               sync_err;
  logic [7:0]         frames_dropped;
  logic               busy;
`ifdef HULL_SEQ_TIMEOUT_EN
  logic               timeout;
`endif

  // Stream source / engine / status consumer side
  modport master (
`ifdef HULL_SEQ_TIMEOUT_EN
    input  timeout,
`endif
    output pix_valid, pix_fg, pix_sof, pix_eol, pix_eof, pix_x, pix_y,
    output hull_done, hull_top,
    input  pt_we, pt_addr, pt_x, pt_y, hull_start, hull_count,
    input  result_valid, hull_size, degenerate, overflow, sync_err,
    input  frames_dropped, busy
  );

  // Sequencer side
  modport slave (
`ifdef HULL_SEQ_TIMEOUT_EN
    output timeout,
`endif
    input  pix_valid, pix_fg, pix_sof, pix_eol, pix_eof, pix_x, pix_y,
    input  hull_done, hull_top,
    output pt_we, pt_addr, pt_x, pt_y, hull_start, hull_count,
    output result_valid, hull_size, degenerate, overflow, sync_err,
    output frames_dropped, busy
  );
endinterface

// File: rtl/hull_frame_sequencer.sv
// Hull engine front end: keeps the leftmost/rightmost foreground pixel of
// each row, writes them to point memory in row order, kicks the engine at
// end of frame and reports the result. Frames arriving while the engine is
// busy are dropped and counted.
// Optional: define HULL_SEQ_TIMEOUT_EN for a WAIT_HULL watchdog with a
// sticky timeout output.
module hull_frame_sequencer #(
  parameter int MAX_POINTS     = 256,
  parameter int CNT_W          = 9,
  parameter int COORD_W        = 11,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                   clk,
  input logic                   rst,
  hull_frame_sequencer_if.slave bus
);

  if (MAX_POINTS >= (1 << CNT_W) || TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("hull_frame_sequencer: CNT_W cannot hold MAX_POINTS or TIMEOUT_CYCLES < 1");
  end

  localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_POINTS);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_FLUSH_L, S_FLUSH_R, S_START, S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               row_hit_q, row_hit_d;
  logic [COORD_W-1:0] row_min_q, row_min_d;
  logic [COORD_W-1:0] row_max_q, row_max_d;
  logic [COORD_W-1:0] row_y_q, row_y_d;
  logic               eof_q, eof_d;
  logic               frm_ovf_q, frm_ovf_d;
  logic               pt_we_q, pt_we_d;
  logic [CNT_W-1:0]   pt_addr_q, pt_addr_d;
  logic [COORD_W-1:0] pt_x_q, pt_x_d;
  logic [COORD_W-1:0] pt_y_q, pt_y_d;
  logic               hull_start_q, hull_start_d;
  logic [CNT_W-1:0]   hull_count_q, hull_count_d;
  logic               result_q, result_d;
  logic [CNT_W-1:0]   hull_size_q, hull_size_d;
  logic               degen_q, degen_d;
  logic               ovf_q, ovf_d;
  logic               sync_err_q, sync_err_d;
  logic [7:0]         drop_q, drop_d;
  logic               tmo_hit;

  // A sof in IDLE opens a frame; a sof inside COLLECT restarts it. Either
  // way the sof pixel is itself processed as a collected pixel.
  logic               sof_v, idle_sof, restart, take, fg, hit_base;
  logic [CNT_W-1:0]   cnt_base;
  logic               row_hit_n;
  logic [COORD_W-1:0] row_min_n, row_max_n;
  logic               flush_r_wr;

  assign sof_v      = bus.pix_valid & bus.pix_sof;
  assign idle_sof   = (state_q == S_IDLE) & sof_v;
  assign restart    = (state_q == S_COLLECT) & sof_v;
  assign take       = idle_sof | ((state_q == S_COLLECT) & bus.pix_valid);
  assign hit_base   = row_hit_q & ~(idle_sof | restart);
  assign cnt_base   = (idle_sof | restart) ? '0 : cnt_q;
  assign fg         = take & bus.pix_fg;
  assign row_hit_n  = hit_base | fg;
  assign row_min_n  = (fg & ~hit_base) ? bus.pix_x : row_min_q;
  assign row_max_n  = fg ? bus.pix_x : row_max_q;
  // Right point only when it is a distinct pixel from the left one
  assign flush_r_wr = row_hit_q & (row_max_q != row_min_q);

`ifdef HULL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;

  assign tmo_hit = (state_q == S_WAIT) && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles spent in WAIT_HULL; timeout is sticky
  always_comb begin
    wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + TW'(1) : '0;
    timeout_d  = timeout_q | (tmo_hit & ~bus.hull_done);
  end

  // Watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      row_hit_q    <= 1'b0;
      row_min_q    <= '0;
      row_max_q    <= '0;
      row_y_q      <= '0;
      eof_q        <= 1'b0;
      frm_ovf_q    <= 1'b0;
      pt_we_q      <= 1'b0;
      pt_addr_q    <= '0;
      pt_x_q       <= '0;
      pt_y_q       <= '0;
      hull_start_q <= 1'b0;
      hull_count_q <= '0;
      result_q     <= 1'b0;
      hull_size_q  <= '0;
      degen_q      <= 1'b0;
      ovf_q        <= 1'b0;
      sync_err_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_hit_q    <= row_hit_d;
      row_min_q    <= row_min_d;
      row_max_q    <= row_max_d;
      row_y_q      <= row_y_d;
      eof_q        <= eof_d;
      frm_ovf_q    <= frm_ovf_d;
      pt_we_q      <= pt_we_d;
      pt_addr_q    <= pt_addr_d;
      pt_x_q       <= pt_x_d;
      pt_y_q       <= pt_y_d;
      hull_start_q <= hull_start_d;
      hull_count_q <= hull_count_d;
      result_q     <= result_d;
      hull_size_q  <= hull_size_d;
      degen_q      <= degen_d;
      ovf_q        <= ovf_d;
      sync_err_q   <= sync_err_d;
      drop_q       <= drop_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (idle_sof) state_d = bus.pix_eol ? S_FLUSH_L : S_COLLECT;
      S_COLLECT: if (bus.pix_valid && bus.pix_eol) state_d = S_FLUSH_L;
      S_FLUSH_L: state_d = S_FLUSH_R;
      S_FLUSH_R: state_d = eof_q ? S_START : S_COLLECT;
      S_START:   state_d = (cnt_q >= CNT_W'(3)) ? S_WAIT : S_IDLE;
      S_WAIT:    if (bus.hull_done || tmo_hit) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values. Pulses are decoded one state early so the
  // left point is on the bus during FLUSH_L and the right point in FLUSH_R.
  always_comb begin
    cnt_d        = cnt_q;
    row_hit_d    = row_hit_q;
    row_min_d    = row_min_q;
    row_max_d    = row_max_q;
    row_y_d      = row_y_q;
    eof_d        = eof_q;
    frm_ovf_d    = frm_ovf_q;
    pt_we_d      = 1'b0;
    pt_addr_d    = pt_addr_q;
    pt_x_d       = pt_x_q;
    pt_y_d       = pt_y_q;
    hull_start_d = 1'b0;
    hull_count_d = hull_count_q;
    result_d     = 1'b0;
    hull_size_d  = hull_size_q;
    degen_d      = degen_q;
    ovf_d        = ovf_q;
    sync_err_d   = sync_err_q;
    drop_d       = drop_q;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (restart) sync_err_d = 1'b1;
        if (idle_sof || restart) begin
          cnt_d     = '0;
          frm_ovf_d = 1'b0;
          eof_d     = 1'b0;
        end
        if (take) begin
          row_hit_d = row_hit_n;
          row_min_d = row_min_n;
          row_max_d = row_max_n;
          if (bus.pix_eol) begin
            row_y_d = bus.pix_y;
            eof_d   = bus.pix_eof;
            if (row_hit_n) begin
              if (cnt_base < MAXP) begin
                pt_we_d   = 1'b1;
                pt_addr_d = cnt_base;
                pt_x_d    = row_min_n;
                pt_y_d    = bus.pix_y;
                cnt_d     = cnt_base + CNT_W'(1);
              end else begin
                frm_ovf_d = 1'b1;
              end
            end
          end
        end
      end
      S_FLUSH_L: begin
        if (bus.pix_valid) sync_err_d = 1'b1;
        if (flush_r_wr) begin
          if (cnt_q < MAXP) begin
            pt_we_d   = 1'b1;
            pt_addr_d = cnt_q;
            pt_x_d    = row_max_q;
            pt_y_d    = row_y_q;
            cnt_d     = cnt_q + CNT_W'(1);
          end else begin
            frm_ovf_d = 1'b1;
          end
        end
      end
      S_FLUSH_R: begin
        if (bus.pix_valid) sync_err_d = 1'b1;
        row_hit_d = 1'b0;
      end
      S_START: begin
        if (cnt_q >= CNT_W'(3)) begin
          hull_start_d = 1'b1;
          hull_count_d = cnt_q;
        end else begin
          degen_d     = 1'b1;
          hull_size_d = cnt_q;
          ovf_d       = frm_ovf_q;
          result_d    = 1'b1;
        end
      end
      S_WAIT: begin
        // A frame starting now is lost even if the engine finishes this cycle
        if (sof_v && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        if (bus.hull_done) begin
          hull_size_d = bus.hull_top;
          degen_d     = 1'b0;
          ovf_d       = frm_ovf_q;
          result_d    = 1'b1;
        end else if (tmo_hit) begin
          hull_size_d = '0;
          degen_d     = 1'b0;
          ovf_d       = frm_ovf_q;
          result_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.pt_we          = pt_we_q;
  assign bus.pt_addr        = pt_addr_q;
  assign bus.pt_x           = pt_x_q;
  assign bus.pt_y           = pt_y_q;
  assign bus.hull_start     = hull_start_q;
  assign bus.hull_count     = hull_count_q;
  assign bus.result_valid   = result_q;
  assign bus.hull_size      = hull_size_q;
  assign bus.degenerate     = degen_q;
  assign bus.overflow       = ovf_q;
  assign bus.sync_err       = sync_err_q;
  assign bus.frames_dropped = drop_q;
  assign bus.busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_hull_frame_sequencer.sv
// Directed bench for hull_frame_sequencer (MAX_POINTS=4, TIMEOUT_CYCLES=16).
module tb_hull_frame_sequencer;
  localparam int CNT_W   = 9;
  localparam int COORD_W = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hull_frame_sequencer_if #(.CNT_W(CNT_W), .COORD_W(COORD_W)) bus ();

  hull_frame_sequencer #(
    .MAX_POINTS(4), .CNT_W(CNT_W), .COORD_W(COORD_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  int ncyc = 0, n_wr = 0, n_eol = 0, n_start = 0, n_res = 0;
  int start_c = 0, res_c = 0;
  logic [31:0]      wr_log [0:63];
  int               wr_c   [0:63];
  int               eol_c  [0:63];
  logic [CNT_W-1:0] cap_count, cap_size;
  logic             cap_deg, cap_ovf;
  logic [7:0]       fgm [0:3];

  // Monitor: log writes, eol pixels, starts and results at the falling edge
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (bus.pt_we) begin
      if (n_wr < 64) begin
        wr_log[n_wr] <= {1'b0, bus.pt_addr, bus.pt_x, bus.pt_y};
        wr_c[n_wr]   <= ncyc;
      end
      n_wr <= n_wr + 1;
    end
    if (bus.pix_valid && bus.pix_eol) begin
      if (n_eol < 64) eol_c[n_eol] <= ncyc;
      n_eol <= n_eol + 1;
    end
    if (bus.hull_start) begin
      n_start   <= n_start + 1;
      cap_count <= bus.hull_count;
      start_c   <= ncyc;
    end
    if (bus.result_valid) begin
      n_res    <= n_res + 1;
      cap_size <= bus.hull_size;
      cap_deg  <= bus.degenerate;
      cap_ovf  <= bus.overflow;
      res_c    <= ncyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int x, input int y);
    return {1'b0, 9'(a), 11'(x), 11'(y)};
  endfunction

  task automatic px(input logic v, input logic f, input logic s, input logic l,
                    input logic e, input int x, input int y);
    bus.pix_valid = v;
    bus.pix_fg    = f;
    bus.pix_sof   = s;
    bus.pix_eol   = l;
    bus.pix_eof   = e;
    bus.pix_x     = COORD_W'(x);
    bus.pix_y     = COORD_W'(y);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) px(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Raster frame from fgm, with two blanking cycles after every row
  task automatic send_frame(input int w, input int h);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++)
        px(1'b1, fgm[y][x], (x == 0 && y == 0), (x == w - 1), (x == w - 1 && y == h - 1), x, y);
      idle(2);
    end
  endtask

  task automatic engine_done(input int top);
    bus.hull_done = 1'b1;
    bus.hull_top  = CNT_W'(top);
    @(posedge clk); #1;
    bus.hull_done = 1'b0;
  endtask

  task automatic wait_start(input int prev);
    for (int i = 0; i < 100 && n_start == prev; i++) @(posedge clk);
    #1;
    chk("start_seen", n_start, prev + 1);
  endtask

  task automatic wait_res(input int prev);
    for (int i = 0; i < 100 && n_res == prev; i++) @(posedge clk);
    #1;
    chk("result_seen", n_res, prev + 1);
  endtask

  task automatic set_square();
    fgm[0] = 8'h00; fgm[1] = 8'h3C; fgm[2] = 8'h3C; fgm[3] = 8'h00;
  endtask

  task automatic set_single();
    fgm[0] = 8'h08; fgm[1] = 8'h00; fgm[2] = 8'h00; fgm[3] = 8'h00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim_time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, eb, sb, rb;
    bus.pix_valid = 0; bus.pix_fg = 0; bus.pix_sof = 0; bus.pix_eol = 0;
    bus.pix_eof = 0; bus.pix_x = '0; bus.pix_y = '0;
    bus.hull_done = 0; bus.hull_top = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pt_we",     32'(bus.pt_we), 0);
    chk("rst_busy",      32'(bus.busy), 0);
    chk("rst_hull_count", 32'(bus.hull_count), 0);
    chk("rst_result",    32'(bus.result_valid), 0);
    chk("rst_dropped",   32'(bus.frames_dropped), 0);
    chk("rst_sync_err",  32'(bus.sync_err), 0);
    rst = 1'b0;
    idle(2);

    // Square x=2..5 on rows 1..2
    set_square();
    wb = n_wr; sb = n_start; rb = n_res;
    send_frame(8, 4);
    wait_start(sb);
    chk("sq_hull_count", 32'(cap_count), 4);
    idle(3);
    engine_done(4);
    wait_res(rb);
    chk("sq_nwr", n_wr - wb, 4);
    chk("sq_w0", wr_log[wb],     pk(0, 2, 1));
    chk("sq_w1", wr_log[wb + 1], pk(1, 5, 1));
    chk("sq_w2", wr_log[wb + 2], pk(2, 2, 2));
    chk("sq_w3", wr_log[wb + 3], pk(3, 5, 2));
    chk("sq_size", 32'(cap_size), 4);
    chk("sq_deg",  32'(cap_deg), 0);
    chk("sq_ovf",  32'(cap_ovf), 0);
    chk("sq_busy", 32'(bus.busy), 0);

    // Single pixel (3,0): degenerate, no engine start, 1-cycle write latency
    set_single();
    wb = n_wr; eb = n_eol; sb = n_start; rb = n_res;
    send_frame(8, 2);
    wait_res(rb);
    chk("one_nwr", n_wr - wb, 1);
    chk("one_w0", wr_log[wb], pk(0, 3, 0));
    chk("one_latency", wr_c[wb] - eol_c[eb], 1);
    chk("one_nostart", n_start, sb);
    chk("one_size", 32'(cap_size), 1);
    chk("one_deg",  32'(cap_deg), 1);
    chk("one_ovf",  32'(cap_ovf), 0);

    // Overflow: six candidate points into a 4-deep memory
    fgm[0] = 8'h42; fgm[1] = 8'h24; fgm[2] = 8'h81; fgm[3] = 8'h00;
    wb = n_wr; sb = n_start; rb = n_res;
    send_frame(8, 3);
    wait_start(sb);
    chk("ovf_hull_count", 32'(cap_count), 4);
    idle(2);
    engine_done(4);
    wait_res(rb);
    chk("ovf_nwr", n_wr - wb, 4);
    chk("ovf_w0", wr_log[wb],     pk(0, 1, 0));
    chk("ovf_w1", wr_log[wb + 1], pk(1, 6, 0));
    chk("ovf_w2", wr_log[wb + 2], pk(2, 2, 1));
    chk("ovf_w3", wr_log[wb + 3], pk(3, 5, 1));
    chk("ovf_flag", 32'(cap_ovf), 1);
    chk("ovf_size", 32'(cap_size), 4);
    chk("ovf_deg",  32'(cap_deg), 0);

    // Frame arriving during WAIT_HULL is dropped; the next one is processed
    set_square();
    sb = n_start; rb = n_res;
    send_frame(8, 4);
    wait_start(sb);
    wb = n_wr;
    send_frame(8, 4);
    chk("drop_count", 32'(bus.frames_dropped), 1);
    chk("drop_no_wr", n_wr, wb);
    chk("drop_busy", 32'(bus.busy), 1);
    engine_done(3);
    wait_res(rb);
    chk("drop_size", 32'(cap_size), 3);
    chk("drop_ovf",  32'(cap_ovf), 0);
    set_single();
    wb = n_wr; rb = n_res;
    send_frame(8, 2);
    wait_res(rb);
    chk("after_nwr", n_wr - wb, 1);
    chk("after_w0", wr_log[wb], pk(0, 3, 0));
    chk("after_size", 32'(cap_size), 1);

    // Reset while the right point of row 0 is on the bus (FLUSH_R)
    fgm[0] = 8'h48;
    for (int x = 0; x < 8; x++) px(1'b1, fgm[0][x], (x == 0), (x == 7), 1'b0, x, 0);
    idle(1);
    chk("prerst_we", 32'(bus.pt_we), 1);
    rst = 1'b1;
    #1;
    chk("midrst_we",      32'(bus.pt_we), 0);
    chk("midrst_busy",    32'(bus.busy), 0);
    chk("midrst_dropped", 32'(bus.frames_dropped), 0);
    chk("midrst_size",    32'(bus.hull_size), 0);
    chk("midrst_deg",     32'(bus.degenerate), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    set_single();
    wb = n_wr; rb = n_res;
    send_frame(8, 2);
    wait_res(rb);
    chk("postrst_w0", wr_log[wb], pk(0, 3, 0));
    chk("postrst_size", 32'(cap_size), 1);

    // Pixel inside the blanking gap raises sync_err (sticky until reset)
    px(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    px(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    idle(2);
    chk("sync_err_set", 32'(bus.sync_err), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("sync_err_clr", 32'(bus.sync_err), 0);
    idle(2);

`ifdef HULL_SEQ_TIMEOUT_EN
    // Engine never answers: watchdog ends WAIT_HULL after 16 cycles
    set_square();
    sb = n_start; rb = n_res;
    send_frame(8, 4);
    wait_start(sb);
    wait_res(rb);
    chk("tmo_cycles", res_c - start_c, 16);
    chk("tmo_size", 32'(cap_size), 0);
    chk("tmo_flag", 32'(bus.timeout), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hull_frame_sequencer.md
Name: hull_frame_sequencer

Overview:
- Front-end controller for the convex-hull engine.
- Watches the raster pixel stream and keeps only the leftmost and rightmost foreground pixel of each row, as a hull pre-filter.
- Writes those points, ordered by ascending y, into the engine's point memory, starts the engine at end of frame and waits for completion.
- Reports hull size and frame statistics to the rest of the design. Frames that arrive while the engine is busy are dropped.

Parameters:
- MAX_POINTS, 256, point-memory depth; points beyond this are dropped.
- CNT_W, 9, width of point counters; must hold MAX_POINTS.
- COORD_W, 11, x/y coordinate width.
- TIMEOUT_CYCLES, 65535, watchdog limit in WAIT_HULL (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pix_valid  in  1  pixel strobe
- pix_fg  in  1  pixel is foreground
- pix_sof  in  1  first pixel of frame, qualified by pix_valid
- pix_eol  in  1  last pixel of row, qualified by pix_valid
- pix_eof  in  1  last pixel of frame, qualified by pix_valid; always coincides with pix_eol
- pix_x, pix_y  in  COORD_W each  pixel coordinates
- pt_we  out  1  point-memory write enable
- pt_addr  out  CNT_W  point-memory write address
- pt_x, pt_y  out  COORD_W each  point data
- hull_start  out  1  one-cycle engine start
- hull_count  out  CNT_W  number of points handed to the engine
- hull_done  in  1  engine completion pulse
- hull_top  in  CNT_W  hull size reported by the engine
- result_valid  out  1  one-cycle result pulse
- hull_size  out  CNT_W  latched hull size
- degenerate  out  1  last frame had fewer than 3 points
- overflow  out  1  last frame exceeded MAX_POINTS
- sync_err  out  1  sticky stream protocol error
- frames_dropped  out  8  saturating drop counter
- busy  out  1  state is not IDLE

Behaviour:
- Reset: every output is 0, state is IDLE, and all internal counters and row trackers are cleared. Reset asserted mid-frame or mid-hull aborts immediately with no result pulse.

State machine:
- IDLE: on pix_valid&pix_sof, go to COLLECT. Clear point count and the overflow flag. The sof pixel itself is processed as a COLLECT pixel.
- COLLECT, for each pix_valid&pix_fg:
  - If the row has no hit yet: row_min=row_max=pix_x and set row_hit.
  - Otherwise: row_max=pix_x. Pixels arrive in ascending x.
- COLLECT, on pix_valid&pix_eol: latch row_y=pix_y and record eof, then go to FLUSH_L.
- FLUSH_L (1 cycle): if row_hit and count<MAX_POINTS, pulse pt_we with addr=count, (row_min,row_y), and increment count. If row_hit and count==MAX_POINTS, set overflow and drop the point.
- FLUSH_R (1 cycle): same as FLUSH_L, but writes (row_max,row_y) and only when row_max!=row_min. Then clear row_hit and go to START if eof was recorded, else back to COLLECT.
- Blanking rule: the stream guarantees at least 2 idle cycles after eol. A pix_valid seen during FLUSH_L or FLUSH_R is ignored and sets sync_err.
- Restart rule: pix_sof in COLLECT without a prior eof sets sync_err and restarts collection (count cleared).
- START:
  - If count>=3: pulse hull_start for one cycle, drive hull_count=count (held until the next START), go to WAIT_HULL.
  - Else: set degenerate=1, set hull_size=count, pulse result_valid, go to IDLE.
- WAIT_HULL:
  - On hull_done: hull_size=hull_top, degenerate=0, pulse result_valid, go to IDLE.
  - A pix_valid&pix_sof here increments frames_dropped (saturating at 255). That frame is ignored entirely; IDLE waits for the next sof.
- Simultaneous events: if hull_done and sof arrive in the same cycle, the frame still counts as dropped.

Output timing:
- pt_we, hull_start and result_valid are registered single-cycle pulses.
- Latency from the eol pixel to the first pt_we is 1 cycle.
- overflow and degenerate hold until the next frame's result.

Optional Feature:
- Macro HULL_SEQ_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT_HULL. On reaching TIMEOUT_CYCLES without hull_done:
  - go to IDLE;
  - pulse result_valid with hull_size=0;
  - set a sticky output timeout (1 bit, cleared only by reset).
- Not defined: there is no timeout port and WAIT_HULL waits indefinitely.

Test Plan:
- 8x4 frame with a fg square at x=2..5, rows 1..2 -> pt writes (2,1),(5,1),(2,2),(5,2) at addr 0..3; hull_start with hull_count=4; hull_done with hull_top=4 -> result_valid, hull_size=4.
- Single fg pixel at (3,0) in one frame -> one pt write; degenerate=1, hull_size=1, no hull_start.
- MAX_POINTS=4, frame with 3 rows each holding 2 distinct fg pixels -> 4 writes, overflow=1, hull_count=4.
- Second sof arriving while in WAIT_HULL -> frames_dropped=1, no pt_we for that frame; the next frame after completion is processed normally.
- rst asserted during FLUSH_R -> all outputs 0 next edge; the following frame starts at addr 0.
- With HULL_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, hull_done withheld -> result_valid with hull_size=0 and timeout=1 after 16 cycles in WAIT_HULL.
